// File: rtl/intmul_pipe_pkg.sv
// intmul_pipe_pkg: shared sizes for the NTT multiplier and reducer datapath.
// Holds arbitrated data width, default digit width, stage count and tag type.
package intmul_pipe_pkg;

  localparam int DATA_SIZE_ARB = 64;
  localparam int W_SIZE        = 2 * DATA_SIZE_ARB;
  localparam int DIG_DEF       = 16;
  localparam int TAG_W_DEF     = 8;

  function automatic int n_digits(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  localparam int D_DEF = n_digits(DATA_SIZE_ARB, DIG_DEF);

  typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/intmul_stage.sv
// intmul_stage: one B-digit multiply-accumulate stage of intmul_pipe.
// Ports: clk, reset, en; valid/acc/a/b/tag _i in, registered _o out.
module intmul_stage
  import intmul_pipe_pkg::*;
#(
  parameter int N     = DATA_SIZE_ARB,
  parameter int DIG   = DIG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             valid_i,
  input  logic [2*N-1:0]   acc_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [2*N-1:0]   acc_o,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int W  = 2 * N;
  localparam int PW = N + DIG;
  localparam int SH = K * DIG;

  logic [DIG-1:0]   dig;
  logic [PW-1:0]    pp;
  logic [W-1:0]     acc_d, acc_q;
  logic [N-1:0]     a_q, b_d, b_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;

  // b_i arrives pre-shifted, so the current digit is always the low one;
  // the zero fill of the shift extends a partial last digit.
  assign dig   = b_i[DIG-1:0];
  assign pp    = PW'(a_i) * PW'(dig);
  assign acc_d = acc_i + (W'(pp) << SH);
  assign b_d   = b_i >> DIG;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      acc_q   <= acc_d;
      a_q     <= a_i;
      b_q     <= b_d;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign acc_o   = acc_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/intmul_pipe.sv
// intmul_pipe: pipelined exact A*B, one B digit per stage, tag passthrough.
// Ports: clk, reset, en, in_valid/A/B/in_tag in; out_valid/P/out_tag out.
// INTMUL_PIPE_INREG_EN adds an input register stage (latency D+1).
module intmul_pipe
  import intmul_pipe_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_ARB,
  parameter int DIG       = DIG_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [DATA_SIZE-1:0]   A,
  input  logic [DATA_SIZE-1:0]   B,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  output logic [2*DATA_SIZE-1:0] P,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int N = DATA_SIZE;
  localparam int W = 2 * N;
  localparam int D = n_digits(N, DIG);

  logic             s0_valid;
  logic [N-1:0]     s0_a, s0_b;
  logic [TAG_W-1:0] s0_tag;

`ifdef INTMUL_PIPE_INREG_EN
  logic             in_valid_q;
  logic [N-1:0]     a_q, b_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
    end else if (en) begin
      in_valid_q <= in_valid;
      a_q        <= A;
      b_q        <= B;
      tag_q      <= in_tag;
    end
  end

  assign s0_valid = in_valid_q;
  assign s0_a     = a_q;
  assign s0_b     = b_q;
  assign s0_tag   = tag_q;
`else
  assign s0_valid = in_valid;
  assign s0_a     = A;
  assign s0_b     = B;
  assign s0_tag   = in_tag;
`endif

  logic             v_s   [D];
  logic [W-1:0]     acc_s [D];
  logic [N-1:0]     a_s   [D];
  logic [N-1:0]     b_s   [D];
  logic [TAG_W-1:0] tag_s [D];

  for (genvar k = 0; k < D; k++) begin : g_stage
    logic             vi;
    logic [W-1:0]     acci;
    logic [N-1:0]     ai, bi;
    logic [TAG_W-1:0] ti;

    if (k == 0) begin : g_first
      assign vi   = s0_valid;
      assign acci = '0;
      assign ai   = s0_a;
      assign bi   = s0_b;
      assign ti   = s0_tag;
    end else begin : g_next
      assign vi   = v_s[k-1];
      assign acci = acc_s[k-1];
      assign ai   = a_s[k-1];
      assign bi   = b_s[k-1];
      assign ti   = tag_s[k-1];
    end

    intmul_stage #(
      .N    (N),
      .DIG  (DIG),
      .TAG_W(TAG_W),
      .K    (k)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .valid_i(vi),
      .acc_i  (acci),
      .a_i    (ai),
      .b_i    (bi),
      .tag_i  (ti),
      .valid_o(v_s[k]),
      .acc_o  (acc_s[k]),
      .a_o    (a_s[k]),
      .b_o    (b_s[k]),
      .tag_o  (tag_s[k])
    );
  end

  assign out_valid = v_s[D-1];
  assign P         = acc_s[D-1];
  assign out_tag   = tag_s[D-1];

endmodule

// File: tb/tb_intmul_pipe.sv
// tb_intmul_pipe: directed and random checks of intmul_pipe against a
// queue-based product model; also a 60-bit / 24-bit-digit instance.
module tb_intmul_pipe;

`ifdef INTMUL_PIPE_INREG_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  localparam int LAT  = 4 + XTRA;
  localparam int LAT2 = 3 + XTRA;

  logic         clk;
  logic         reset;
  logic         en;
  logic         in_valid;
  logic [63:0]  A, B;
  logic [7:0]   in_tag;
  logic         out_valid;
  logic [127:0] P;
  logic [7:0]   out_tag;

  logic         in2_valid;
  logic [59:0]  A2, B2;
  logic [7:0]   tag2;
  logic         out2_valid;
  logic [119:0] P2;
  logic [7:0]   out2_tag;

  intmul_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .P        (P),
    .out_tag  (out_tag)
  );

  intmul_pipe #(
    .DATA_SIZE(60),
    .DIG      (24),
    .TAG_W    (8)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .en       (1'b1),
    .in_valid (in2_valid),
    .A        (A2),
    .B        (B2),
    .in_tag   (tag2),
    .out_valid(out2_valid),
    .P        (P2),
    .out_tag  (out2_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] p;
    logic [7:0]   tag;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad   = 0;
  int           ecnt  = 0;
  int           nrx   = 0;
  logic         ev    = 1'b0;
  logic [127:0] ep    = '0;
  logic [7:0]   et    = '0;

  task automatic chk(input string n, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", n, got, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge,
  // then compare the outputs just after it.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      q.delete();
      ev = 1'b0;
    end else if (en) begin
      ecnt++;
      if (in_valid)
        q.push_back('{p: 128'(A) * 128'(B), tag: in_tag,
                      due: ecnt + LAT - 1});
      ev = 1'b0;
      if (q.size() != 0 && q[0].due == ecnt) begin
        ev = 1'b1;
        ep = q[0].p;
        et = q[0].tag;
        void'(q.pop_front());
        nrx++;
      end
    end
    #1;
    chk("out_valid", 128'(out_valid), 128'(ev));
    if (ev) begin
      chk("P", P, ep);
      chk("out_tag", 128'(out_tag), 128'(et));
    end
  endtask

  task automatic run_stream(input bit stall, output int span);
    int n0;
    n0   = nrx;
    span = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      A        = 64'(i);
      B        = 64'(i + 1);
      in_tag   = 8'(i);
      step();
      span++;
      if (stall && i == 2) begin
        en     = 1'b0;
        A      = 64'(i + 1);
        B      = 64'(i + 2);
        in_tag = 8'(i + 1);
        repeat (3) begin
          step();
          span++;
        end
        en = 1'b1;
      end
    end
    in_valid = 1'b0;
    for (int n = 0; n < 100 && q.size() != 0; n++) begin
      step();
      span++;
    end
    chk("stream_count", 128'(nrx - n0), 128'(8));
  endtask

  int span;
  int n2;

  initial begin
    reset     = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    in_tag    = '0;
    in2_valid = 1'b0;
    A2        = '0;
    B2        = '0;
    tag2      = '0;

    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_P", P, 128'(0));
    chk("rst_tag", 128'(out_tag), 128'(0));
    chk("rst_P2", 128'(P2), 128'(0));

    // single op
    A = 64'd3; B = 64'd5; in_tag = 8'h11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_P", P, 128'd15);
    chk("t1_tag", 128'(out_tag), 128'h11);
    step();
    chk("t1_valid_off", 128'(out_valid), 128'(0));

    // max operands
    A = '1; B = '1; in_tag = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    chk("max_valid", 128'(out_valid), 128'(1));
    chk("max_P", P, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    repeat (2) step();

    // back-to-back stream, then the same with a 3-cycle stall
    run_stream(1'b0, span);
    chk("span", 128'(span), 128'(7 + LAT));
    run_stream(1'b1, span);
    chk("span_stall", 128'(span), 128'(10 + LAT));

    // reset with ops in flight, input on the reset edge is lost
    for (int i = 0; i < 3; i++) begin
      A = 64'(100 + i); B = 64'(7); in_tag = 8'(i); in_valid = 1'b1;
      step();
    end
    reset = 1'b1;
    A = 64'd7; B = 64'd7; in_tag = 8'hEE;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_P", P, 128'(0));
    repeat (LAT + 2) step();
    A = 64'd9; B = 64'd9; in_tag = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk("post_rst_P", P, 128'd81);
    step();

    // 60-bit operands with a partial last digit
    A2 = 60'h1 << 59;
    B2 = (60'h1 << 59) | 60'h1;
    tag2 = 8'h3C;
    in2_valid = 1'b1;
    step();
    in2_valid = 1'b0;
    n2 = 1;
    while (!out2_valid && n2 < 20) begin
      step();
      n2++;
    end
    chk("p2_latency", 128'(n2), 128'(LAT2));
    chk("p2_P", 128'(P2), (128'h1 << 118) | (128'h1 << 59));
    chk("p2_tag", 128'(out2_tag), 128'h3C);
    step();
    chk("p2_valid_off", 128'(out2_valid), 128'(0));

    // random traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0:       A = '1;
        1:       A = 64'($urandom_range(0, 3));
        default: A = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       B = '1;
        1:       B = 64'($urandom_range(0, 3));
        default: B = {$urandom, $urandom};
      endcase
      in_tag = 8'($urandom);
      step();
    end
    en = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 100 && q.size() != 0; n++) step();
    chk("drain_left", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
